gpio_irq: RTL
=============

// Module: gpio_irq
// PURPOSE
//   Parametrised GPIO peripheral, next generation of the 2-pin GPIO: up to 16 pins,
//   per-pin mode, input synchroniser, per-pin edge interrupts with W1C pending register.
//   Sits on the peripheral bus beside the timer/uart; irq_o feeds the core interrupt input.
// PARAMETERS
//   NUM_IO       16  number of pins, 1..16 (2 ctrl bits per pin in a 32-bit CTRL word)
//   SYNC_STAGES   2  input synchroniser depth, 2..3
// PORTS
//   clk       in   1        system clock
//   rst       in   1        asynchronous, active-low reset
//   we_i      in   1        bus write enable (1 = write)
//   addr_i    in   32       byte address; only addr_i[4:0] decoded
//   data_i    in   32       write data
//   sel_i     in   4        byte-lane write strobes
//   data_o    out  32       read data, combinational on addr_i
//   io_pin_i  in   NUM_IO   raw asynchronous pin inputs
//   io_oe_o   out  NUM_IO   output enable per pin (1 = drive)
//   io_out_o  out  NUM_IO   output value per pin
//   irq_o     out  1        level interrupt, 1 while any enabled pending bit is set
// BEHAVIOUR
//   Registers (offset: name, reset 0):
//     0x00 CTRL     bits[2i+1:2i] mode pin i: 00 hi-Z, 01 output, 10 input, 11 = hi-Z
//     0x04 DATA     W: out_reg[i]; R: bit i = out_reg[i] if output mode, sync_in[i] if input, else 0
//     0x08 INT_CFG  bits[i] enable pin i; bits[16+i] edge: 0 rising, 1 falling   (GPIO_IRQ_EN)
//     0x0C INT_PEND bit i set on enabled edge; write 1 clears, write 0 no effect  (GPIO_IRQ_EN)
//     other offsets: read 0, writes ignored. Bits at/above NUM_IO (and 16+NUM_IO) read 0.
//   - Writes take effect on the clk edge with we_i=1, masked per byte lane by sel_i.
//   - INT_PEND W1C honours sel_i; a write with sel_i=0 changes nothing.
//   - io_oe_o[i] = (mode==01); io_out_o[i] = out_reg[i] & io_oe_o[i]; both 0 in reset.
//   - sync_in = io_pin_i through SYNC_STAGES flops; prev_in = sync_in delayed 1 cycle.
//   - Edge on pin i qualified only when mode==10 and enable set; pin change is visible
//     in INT_PEND/irq_o exactly SYNC_STAGES+1 clk edges after the pin changes.
//   - Simultaneous edge-set and W1C of the same bit: set wins (bit stays 1).
//   - Mode change to input: prev_in tracks continuously, so no spurious edge is generated.
//   - Changing edge polarity does not touch existing pending bits.
//   - irq_o = |(INT_PEND & enable); a register, no combinational path from io_pin_i.
//   - Async reset mid-operation: all registers, sync flops, prev_in -> 0 immediately;
//     data_o still reflects the (zeroed) register state, io_oe_o=0, irq_o=0.
// CONFIGURATION
//   GPIO_IRQ_EN defined: INT_CFG, INT_PEND, edge logic and irq_o as above.
//   Undefined: no interrupt flops; 0x08/0x0C read 0, writes ignored; irq_o tied 0;
//   CTRL/DATA/sync behaviour unchanged.
// STRUCTURE
//   Shared defines header (gpio_defs): register offsets GPIO_CTRL/DATA/INT_CFG/INT_PEND,
//   mode encodings GPIO_MODE_HIZ/OUT/IN, edge encodings; reused by driver tests.
//   One sub-module: gpio_sync (parametrised width x SYNC_STAGES flop chain, async reset).
// TESTING
//   1 Reset: rst=0 mid-write -> all reads 0, io_oe_o=0, io_out_o=0, irq_o=0.
//   2 Byte lanes: write CTRL=0x5555_5555 sel=4'b0001 -> CTRL reads 0x0000_0055, oe=0x000F.
//   3 Output: CTRL=0x1, DATA=0xFFFF -> io_out_o=0x0001, DATA read 0x0001.
//   4 Input: CTRL=0x8 (pin1 input), io_pin_i[1] 0->1 -> DATA[1]=1 after SYNC_STAGES edges.
//   5 IRQ: pin1 input, INT_CFG=0x2, pin1 rise -> INT_PEND=0x2, irq_o=1 at edge SYNC_STAGES+1;
//     write INT_PEND=0x2 -> 0, irq_o=0; falling cfg 0x0002_0002 ignores rise, fires on fall.
//   6 Race: W1C of bit1 in same cycle as new pin1 edge -> INT_PEND[1] stays 1.
//   Run suite with and without GPIO_IRQ_EN (0x08/0x0C read 0, irq_o=0 when off).

Source files
------------

// File: rtl/gpio_irq_pkg.sv
// Shared GPIO register map, mode/edge encodings and byte-lane helper.
// Used by the gpio_irq RTL and by driver-level tests.
package gpio_irq_pkg;

    localparam int unsigned GPIO_ADDR_W = 5;

    localparam logic [GPIO_ADDR_W-1:0] GPIO_CTRL     = 5'h00;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_DATA     = 5'h04;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_INT_CFG  = 5'h08;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_INT_PEND = 5'h0C;

    typedef enum logic [1:0] {
        GPIO_MODE_HIZ  = 2'b00,
        GPIO_MODE_OUT  = 2'b01,
        GPIO_MODE_IN   = 2'b10,
        GPIO_MODE_HIZ2 = 2'b11
    } gpio_mode_e;

    typedef enum logic {
        GPIO_EDGE_RISE = 1'b0,
        GPIO_EDGE_FALL = 1'b1
    } gpio_edge_e;

    // Expand the 4 byte strobes into a 32-bit bit-write mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// WIDTH-wide input synchroniser, STAGES flops deep, async active-low reset.
module gpio_sync #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = d_i;
        for (int unsigned s = 1; s < STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gpio_irq.sv
// Parametrised GPIO: per-pin mode, synchronised inputs, optional edge interrupts.
// Interrupt block (INT_CFG, INT_PEND, irq_o) is built only when GPIO_IRQ_EN is defined.
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int unsigned NUM_IO      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    input  logic [3:0]        sel_i,
    output logic [31:0]       data_o,
    input  logic [NUM_IO-1:0] io_pin_i,
    output logic [NUM_IO-1:0] io_oe_o,
    output logic [NUM_IO-1:0] io_out_o,
    output logic              irq_o
);

    localparam int unsigned CTRL_W = 2 * NUM_IO;

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [NUM_IO-1:0] out_q, out_d;
    logic [NUM_IO-1:0] oe_q, oe_d;
    logic [NUM_IO-1:0] pin_out_q, pin_out_d;
    logic [NUM_IO-1:0] sync_in;
    logic [NUM_IO-1:0] mode_out, mode_in;
    logic [31:0]       wmask;
    logic              wr_ctrl, wr_data;
    logic [26:0]       unused_addr;

    assign unused_addr = addr_i[31:GPIO_ADDR_W];

    gpio_sync #(
        .WIDTH  (NUM_IO),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (io_pin_i),
        .q_o (sync_in)
    );

    // CTRL/DATA write path and pin-mode decode
    always_comb begin
        wmask   = lane_mask(sel_i);
        wr_ctrl = we_i && (addr_i[GPIO_ADDR_W-1:0] == GPIO_CTRL);
        wr_data = we_i && (addr_i[GPIO_ADDR_W-1:0] == GPIO_DATA);
        ctrl_d  = ctrl_q;
        out_d   = out_q;
        if (wr_ctrl) begin
            ctrl_d = (ctrl_q & ~wmask[CTRL_W-1:0]) | (data_i[CTRL_W-1:0] & wmask[CTRL_W-1:0]);
        end
        if (wr_data) begin
            out_d = (out_q & ~wmask[NUM_IO-1:0]) | (data_i[NUM_IO-1:0] & wmask[NUM_IO-1:0]);
        end
        for (int unsigned i = 0; i < NUM_IO; i++) begin
            mode_out[i] = (ctrl_q[2*i +: 2] == GPIO_MODE_OUT);
            mode_in[i]  = (ctrl_q[2*i +: 2] == GPIO_MODE_IN);
            oe_d[i]     = (ctrl_d[2*i +: 2] == GPIO_MODE_OUT);
        end
        pin_out_d = out_d & oe_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q    <= '0;
            out_q     <= '0;
            oe_q      <= '0;
            pin_out_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            pin_out_q <= pin_out_d;
        end
    end

    assign io_oe_o  = oe_q;
    assign io_out_o = pin_out_q;

`ifdef GPIO_IRQ_EN
    logic [NUM_IO-1:0] int_en_q, int_en_d;
    logic [NUM_IO-1:0] int_edge_q, int_edge_d;
    logic [NUM_IO-1:0] pend_q, pend_d;
    logic [NUM_IO-1:0] prev_q;
    logic [NUM_IO-1:0] edge_hit, pend_clr;
    logic [31:0]       cfg_cur, cfg_new;
    logic              irq_q, irq_d;
    logic              wr_cfg, wr_pend;

    // Edge qualification and W1C pending; a new edge wins over a same-cycle clear
    always_comb begin
        wr_cfg     = we_i && (addr_i[GPIO_ADDR_W-1:0] == GPIO_INT_CFG);
        wr_pend    = we_i && (addr_i[GPIO_ADDR_W-1:0] == GPIO_INT_PEND);
        cfg_cur    = 32'(int_en_q) | (32'(int_edge_q) << 16);
        cfg_new    = (cfg_cur & ~wmask) | (data_i & wmask);
        int_en_d   = int_en_q;
        int_edge_d = int_edge_q;
        if (wr_cfg) begin
            int_en_d   = cfg_new[NUM_IO-1:0];
            int_edge_d = cfg_new[16 +: NUM_IO];
        end
        pend_clr = wr_pend ? (data_i[NUM_IO-1:0] & wmask[NUM_IO-1:0]) : '0;
        for (int unsigned i = 0; i < NUM_IO; i++) begin
            edge_hit[i] = mode_in[i] && int_en_q[i] &&
                          ((int_edge_q[i] == GPIO_EDGE_FALL) ? (prev_q[i] && !sync_in[i])
                                                             : (sync_in[i] && !prev_q[i]));
        end
        pend_d = (pend_q & ~pend_clr) | edge_hit;
        irq_d  = |(pend_d & int_en_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_en_q   <= '0;
            int_edge_q <= '0;
            pend_q     <= '0;
            prev_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            int_en_q   <= int_en_d;
            int_edge_q <= int_edge_d;
            pend_q     <= pend_d;
            prev_q     <= sync_in;
            irq_q      <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    // Read mux, combinational on the low address bits
    always_comb begin
        data_o = '0;
        case (addr_i[GPIO_ADDR_W-1:0])
            GPIO_CTRL: data_o = 32'(ctrl_q);
            GPIO_DATA: data_o = 32'((out_q & mode_out) | (sync_in & mode_in));
`ifdef GPIO_IRQ_EN
            GPIO_INT_CFG:  data_o = cfg_cur;
            GPIO_INT_PEND: data_o = 32'(pend_q);
`else
            GPIO_INT_CFG, GPIO_INT_PEND: data_o = '0;
`endif
            default: data_o = '0;
        endcase
    end

endmodule
